apb_fifo_periph_p: RTL and testbench
====================================

// Module: apb_fifo_periph_p
// PURPOSE
//  APB3 slave exposing a parametrised synchronous FIFO as a CPU peripheral; successor to the fixed 8-bit FIFO peripheral.
//  Adds configurable width/depth, fill-level readout, programmable threshold interrupt, sticky overflow/underflow, flush and PSLVERR.
//  Sits on the APB bus behind the APB master/decoder alongside the other peripherals.
// PARAMETERS
//  DATA_W  8   FIFO entry width, 1..32; PWDATA[DATA_W-1:0] pushed, PRDATA upper bits zero
//  DEPTH   16  entries; power of 2, 2..256
//  CNT_W   $clog2(DEPTH)+1  level counter width (localparam, not overridable)
// PORTS
//  PCLK      in   1   APB clock; the only clock
//  PRESET    in   1   asynchronous, active-high reset
//  PADDR     in   4   byte address; word aligned, PADDR[1:0] ignored
//  PWDATA    in   32  write data
//  PWRITE    in   1   1 = write, 0 = read
//  PENABLE   in   1   APB access phase
//  PSEL      in   1   slave select
//  PRDATA    out  32  read data, valid when PREADY=1 in access phase
//  PREADY    out  1   transfer complete
//  PSLVERR   out  1   error response, valid with PREADY
//  fifo_irq  out  1   level interrupt, registered
// BEHAVIOUR
//  Register map (offset):
//   0x0 FSR RO : [0] empty [1] full [2] ovf sticky [3] udf sticky [4] thr (level>=THR) [15:8] level
//   0x4 FWD WO : push PWDATA[DATA_W-1:0]
//   0x8 FRD RO : pop; returns head entry zero-extended
//   0xC FCR RW : [0] irq_en [1] flush (write-1, self-clearing, reads 0) [2] W1C ovf [3] W1C udf [15:8] THR
//  Reset: pointers/level 0, empty=1, full=0, ovf=udf=0, irq_en=0, THR=DEPTH/2, PRDATA=0, PREADY=0, PSLVERR=0, fifo_irq=0.
//  Handshake: setup (PSEL&!PENABLE) never asserts PREADY. Access phase:
//   FSR/FWD/FCR/unmapped: PREADY=1 in the first access cycle (zero wait).
//   FRD: one wait state; PREADY=0 in first access cycle, head registered into PRDATA, PREADY=1 in second.
//  Side effects fire exactly once per transfer, on the PCLK edge where PSEL&PENABLE&PREADY.
//  Push while full: entry dropped, ovf<=1, PSLVERR=1. Pop while empty: PRDATA=0, udf<=1, PSLVERR=1, pointers unchanged.
//  Pointers wrap modulo DEPTH; full when level==DEPTH; level counts 0..DEPTH inclusive.
//  Read to FWD, write to FSR/FRD, or unmapped address: no effect, PRDATA=0, PSLVERR=1.
//  Flush: level/pointers to 0 on the write's completion edge; does not clear ovf/udf or FCR fields.
//  FCR write with flush=1 and W1C bits set in the same word: all applied on the same edge.
//  fifo_irq <= irq_en & (thr | ovf | udf); updates one cycle after the causing state change.
//  THR=0 -> thr always 1; THR>DEPTH -> thr never 1.
//  PRDATA is held at 0 outside read completion cycles.
//  PRESET asserted mid-transfer: all state cleared immediately; transfer abandoned without side effect.
// STRUCTURE
//  Package fifo_apb_pkg: register offsets (FSR/FWD/FRD/FCR), FSR/FCR bit-position constants, typedef enum {IDLE, ACCESS, RD_WAIT} apb_state_e.
//  Sub-module sync_fifo_core #(DATA_W, DEPTH): push/pop/flush -> rdata (head, combinational), full, empty, level; no APB knowledge.
//  Top: APB FSM, register decode, sticky flags, FCR, irq register.
// TESTING
//  Reset, read FSR -> 0x0000_0001 (empty=1, level=0), PSLVERR=0.
//  Push 0xAA, 0xBB; FSR level=2; pop FRD twice -> 0xAA then 0xBB, each PREADY one cycle after PENABLE; FSR empty=1.
//  DEPTH=16: 16 pushes -> full=1, level=16; 17th push -> PSLVERR=1, ovf=1; 16 pops return the original order.
//  Pop when empty -> PRDATA=0, PSLVERR=1, udf=1; FCR write 0x8 clears udf.
//  FCR=0x0000_0301 (THR=3, irq_en): fifo_irq=0 at level 2, 1 one cycle after 3rd push; flush write (0x2) -> level 0, irq drops.
//  Pointer wrap: 10 push/10 pop, then 12 push/12 pop with DEPTH=16 -> data intact; PRESET mid-FRD wait -> PREADY=0, level 0.

Source files
------------

// File: rtl/fifo_apb_pkg.sv
// Shared definitions for the APB FIFO peripheral: register word offsets,
// status/control bit positions and the APB handshake state encoding.
package fifo_apb_pkg;

    // Register word index, taken from PADDR[3:2]
    localparam logic [1:0] REG_FSR = 2'd0;
    localparam logic [1:0] REG_FWD = 2'd1;
    localparam logic [1:0] REG_FRD = 2'd2;
    localparam logic [1:0] REG_FCR = 2'd3;

    // FSR bit positions
    localparam int FSR_EMPTY   = 0;
    localparam int FSR_FULL    = 1;
    localparam int FSR_OVF     = 2;
    localparam int FSR_UDF     = 3;
    localparam int FSR_THR     = 4;
    localparam int FSR_LVL_LSB = 8;

    // FCR bit positions
    localparam int FCR_IRQ_EN  = 0;
    localparam int FCR_FLUSH   = 1;
    localparam int FCR_CLR_OVF = 2;
    localparam int FCR_CLR_UDF = 3;
    localparam int FCR_THR_LSB = 8;

    // APB slave handshake states; RD_WAIT is the single wait state of FRD
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } apb_state_e;

endpackage

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO storage: push/pop/flush with a combinational head output
// and a level counter that spans 0..DEPTH inclusive. Knows nothing of APB.
module sync_fifo_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == CNT_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    // Storage array has no reset; only the entry at wr_ptr is written on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; flush wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/apb_fifo_periph_p.sv
// APB3 slave wrapping sync_fifo_core as a CPU peripheral: status, push,
// pop (one wait state), control with threshold interrupt, sticky error flags.
// Side effects happen only on the edge that completes a transfer.
module apb_fifo_periph_p
    import fifo_apb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        fifo_irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Handshake: a transfer starts with setup (PSEL & !PENABLE), then access
    // (PSEL & PENABLE). PREADY rises only in access; the transfer completes on
    // the edge where PSEL & PENABLE & PREADY, and PSLVERR/PRDATA are valid then.

    apb_state_e        state_q;
    apb_state_e        state_d;

    logic [1:0]        reg_sel;
    logic              xfer;
    logic              is_frd_rd;

    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_level;

    logic              push;
    logic              pop;
    logic              fcr_wr;
    logic              cap_head;
    logic              flush;

    logic              ovf_q;
    logic              udf_q;
    logic              irq_en_q;
    logic [7:0]        thr_q;
    logic [31:0]       prdata_q;

    logic [8:0]        lvl_ext;
    logic [7:0]        lvl_byte;
    logic              thr_hit;
    logic [31:0]       fsr_val;
    logic [31:0]       fcr_val;

    wire unused_ok = ^{PADDR[1:0], PWDATA};

    assign reg_sel   = PADDR[3:2];
    assign xfer      = PSEL & PENABLE;
    assign is_frd_rd = ~PWRITE & (reg_sel == REG_FRD);
    assign flush     = fcr_wr & PWDATA[FCR_FLUSH];

    sync_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (PWDATA[DATA_W-1:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Status/control words; level saturates in the 8-bit field only when DEPTH=256 and full
    always_comb begin
        lvl_ext  = 9'(fifo_level);
        lvl_byte = lvl_ext[8] ? 8'hFF : lvl_ext[7:0];
        thr_hit  = (lvl_ext >= {1'b0, thr_q});
        fsr_val  = '0;
        fsr_val[FSR_EMPTY] = fifo_empty;
        fsr_val[FSR_FULL]  = fifo_full;
        fsr_val[FSR_OVF]   = ovf_q;
        fsr_val[FSR_UDF]   = udf_q;
        fsr_val[FSR_THR]   = thr_hit;
        fsr_val[FSR_LVL_LSB +: 8] = lvl_byte;
        fcr_val  = '0;
        fcr_val[FCR_IRQ_EN] = irq_en_q;
        fcr_val[FCR_THR_LSB +: 8] = thr_q;
    end

    // FSM state register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only FRD reads detour through RD_WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (PSEL & ~PENABLE) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (xfer) begin
                    state_d = is_frd_rd ? RD_WAIT : IDLE;
                end else if (~PSEL) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: PREADY/PSLVERR/PRDATA and the completion-edge strobes
    always_comb begin
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        PRDATA   = '0;
        push     = 1'b0;
        pop      = 1'b0;
        fcr_wr   = 1'b0;
        cap_head = 1'b0;
        case (state_q)
            ACCESS: begin
                if (xfer) begin
                    if (is_frd_rd) begin
                        cap_head = 1'b1;
                    end else begin
                        PREADY = 1'b1;
                        if (PWRITE) begin
                            case (reg_sel)
                                REG_FWD: begin
                                    push    = 1'b1;
                                    PSLVERR = fifo_full;
                                end
                                REG_FCR: fcr_wr  = 1'b1;
                                default: PSLVERR = 1'b1;
                            endcase
                        end else begin
                            case (reg_sel)
                                REG_FSR: PRDATA  = fsr_val;
                                REG_FCR: PRDATA  = fcr_val;
                                default: PSLVERR = 1'b1;
                            endcase
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (xfer) begin
                    PREADY  = 1'b1;
                    pop     = 1'b1;
                    PSLVERR = fifo_empty;
                    PRDATA  = prdata_q;
                end
            end
            default: ;
        endcase
    end

    // Head capture for FRD during the wait state; zero when popping an empty FIFO
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            prdata_q <= '0;
        end else if (cap_head) begin
            prdata_q <= fifo_empty ? 32'd0 : 32'(fifo_rdata);
        end else if (state_q == RD_WAIT) begin
            prdata_q <= '0;
        end
    end

    // Sticky flags and FCR fields; W1C and flush share the FCR write edge
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            thr_q    <= 8'(DEPTH / 2);
        end else begin
            if (push & fifo_full) begin
                ovf_q <= 1'b1;
            end
            if (pop & fifo_empty) begin
                udf_q <= 1'b1;
            end
            if (fcr_wr) begin
                irq_en_q <= PWDATA[FCR_IRQ_EN];
                thr_q    <= PWDATA[FCR_THR_LSB +: 8];
                if (PWDATA[FCR_CLR_OVF]) begin
                    ovf_q <= 1'b0;
                end
                if (PWDATA[FCR_CLR_UDF]) begin
                    udf_q <= 1'b0;
                end
            end
        end
    end

    // Registered level interrupt, one cycle behind the state it reflects
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            fifo_irq <= 1'b0;
        end else begin
            fifo_irq <= irq_en_q & (thr_hit | ovf_q | udf_q);
        end
    end

endmodule

// File: tb/tb_apb_fifo_periph_p.sv
// Bench for apb_fifo_periph_p (DATA_W=8, DEPTH=16): vector table of single
// APB transfers plus hand-written multi-cycle sequences.
module tb_apb_fifo_periph_p;

    logic        PCLK;
    logic        PRESET;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        fifo_irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    localparam logic [3:0] A_FSR = 4'h0;
    localparam logic [3:0] A_FWD = 4'h4;
    localparam logic [3:0] A_FRD = 4'h8;
    localparam logic [3:0] A_FCR = 4'hC;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_wait;
    } vec_t;

    vec_t vecs[15];

    apb_fifo_periph_p #(
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .fifo_irq (fifo_irq)
    );

    // Clock
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer; returns data, error and the number of wait cycles
    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        logic done;
        done  = 1'b0;
        rdata = '0;
        err   = 1'b0;
        waits = 0;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge PCLK);
        check("setup_pready", 32'(PREADY), 32'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int n = 0; n < 8 && !done; n++) begin
            @(negedge PCLK);
            if (PREADY) begin
                rdata = PRDATA;
                err   = PSLVERR;
                done  = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!done) check("pready_timeout", 32'd0, 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic do_write(input string name, input logic [3:0] addr, input logic [31:0] d, input logic exp_err);
        logic [31:0] r;
        logic e;
        int w;
        apb_xfer(1'b1, addr, d, r, e, w);
        check({name, "_err"}, 32'(e), 32'(exp_err));
    endtask

    task automatic do_read(input string name, input logic [3:0] addr, input logic [31:0] exp, input logic exp_err);
        logic [31:0] r;
        logic e;
        int w;
        apb_xfer(1'b0, addr, 32'd0, r, e, w);
        check({name, "_data"}, r, exp);
        check({name, "_err"}, 32'(e), 32'(exp_err));
    endtask

    task automatic push_sb(input logic [7:0] d);
        exp_q.push_back(d);
        do_write("push", A_FWD, {24'hABCDEF, d}, 1'b0);
    endtask

    task automatic pop_sb();
        logic [7:0] d;
        d = exp_q.pop_front();
        do_read("pop", A_FRD, 32'(d), 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          w;

        // Vector table: {write, addr, wdata, expected rdata, expected err, expected waits}
        vecs[0]  = '{1'b0, A_FSR, 32'h0,         32'h0000_0001, 1'b0, 0};
        vecs[1]  = '{1'b1, A_FWD, 32'hFFFF_FFAA, 32'h0,         1'b0, 0};
        vecs[2]  = '{1'b1, A_FWD, 32'h0000_00BB, 32'h0,         1'b0, 0};
        vecs[3]  = '{1'b0, A_FSR, 32'h0,         32'h0000_0200, 1'b0, 0};
        vecs[4]  = '{1'b0, A_FRD, 32'h0,         32'h0000_00AA, 1'b0, 1};
        vecs[5]  = '{1'b0, A_FRD, 32'h0,         32'h0000_00BB, 1'b0, 1};
        vecs[6]  = '{1'b0, A_FSR, 32'h0,         32'h0000_0001, 1'b0, 0};
        vecs[7]  = '{1'b0, A_FRD, 32'h0,         32'h0000_0000, 1'b1, 1};
        vecs[8]  = '{1'b0, A_FSR, 32'h0,         32'h0000_0009, 1'b0, 0};
        vecs[9]  = '{1'b1, A_FCR, 32'h0000_0008, 32'h0,         1'b0, 0};
        vecs[10] = '{1'b0, A_FCR, 32'h0,         32'h0000_0000, 1'b0, 0};
        vecs[11] = '{1'b0, A_FWD, 32'h0,         32'h0000_0000, 1'b1, 0};
        vecs[12] = '{1'b1, A_FSR, 32'h0000_0005, 32'h0,         1'b1, 0};
        vecs[13] = '{1'b1, A_FRD, 32'h0000_0077, 32'h0,         1'b1, 0};
        vecs[14] = '{1'b0, A_FSR, 32'h0,         32'h0000_0011, 1'b0, 0};

        // Reset
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_irq", 32'(fifo_irq), 32'd0);
        PRESET = 1'b0;

        // Table-driven single transfers
        for (int i = 0; i < 15; i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, r, e, w);
            check($sformatf("vec%0d_data", i), r, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_wait", i), 32'(w), 32'(vecs[i].exp_wait));
        end

        // Fill to full, overflow, drain in order
        do_write("fcr_thr16", A_FCR, 32'h0000_1000, 1'b0);
        for (int i = 0; i < 16; i++) push_sb(8'(i * 13 + 7));
        do_read("fsr_full", A_FSR, 32'h0000_1012, 1'b0);
        do_write("push_ovf", A_FWD, 32'h0000_00EE, 1'b1);
        do_read("fsr_ovf", A_FSR, 32'h0000_1016, 1'b0);
        for (int i = 0; i < 16; i++) pop_sb();
        do_read("fsr_drained", A_FSR, 32'h0000_0005, 1'b0);
        do_write("clr_ovf", A_FCR, 32'h0000_1004, 1'b0);
        do_read("fsr_ovf_clr", A_FSR, 32'h0000_0001, 1'b0);

        // Threshold interrupt and flush
        do_write("fcr_irq", A_FCR, 32'h0000_0301, 1'b0);
        do_write("irq_p1", A_FWD, 32'h11, 1'b0);
        do_write("irq_p2", A_FWD, 32'h22, 1'b0);
        repeat (2) @(posedge PCLK);
        #1;
        check("irq_lvl2", 32'(fifo_irq), 32'd0);
        do_write("irq_p3", A_FWD, 32'h33, 1'b0);
        check("irq_same_edge", 32'(fifo_irq), 32'd0);
        @(posedge PCLK); #1;
        check("irq_lvl3", 32'(fifo_irq), 32'd1);
        do_read("fsr_lvl3", A_FSR, 32'h0000_0310, 1'b0);
        do_write("flush", A_FCR, 32'h0000_0303, 1'b0);
        @(posedge PCLK); #1;
        check("irq_after_flush", 32'(fifo_irq), 32'd0);
        do_read("fsr_flushed", A_FSR, 32'h0000_0001, 1'b0);
        do_read("fcr_rb", A_FCR, 32'h0000_0301, 1'b0);

        // Pointer wrap with random data
        do_write("fcr_thr16b", A_FCR, 32'h0000_1000, 1'b0);
        for (int i = 0; i < 10; i++) push_sb(8'($urandom_range(0, 255)));
        for (int i = 0; i < 10; i++) pop_sb();
        for (int i = 0; i < 12; i++) push_sb(8'($urandom_range(0, 255)));
        do_read("fsr_wrap12", A_FSR, 32'h0000_0C00, 1'b0);
        for (int i = 0; i < 12; i++) pop_sb();
        do_read("fsr_wrap_empty", A_FSR, 32'h0000_0001, 1'b0);

        // Reset during the FRD wait state
        do_write("pre_rst_push", A_FWD, 32'h5A, 1'b0);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_FRD;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("frd_wait_pready", 32'(PREADY), 32'd0);
        #1;
        PRESET = 1'b1;
        #1;
        check("mid_rst_pready", 32'(PREADY), 32'd0);
        check("mid_rst_prdata", PRDATA, 32'd0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        do_read("fsr_after_rst", A_FSR, 32'h0000_0001, 1'b0);
        do_read("fcr_after_rst", A_FCR, 32'h0000_0800, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
